// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg: immediate-format encodings and occupancy states shared by the immediate generator
package imm_gen_pipe_pkg;
  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] U_TYPE = 3'd3;
  localparam logic [2:0] J_TYPE = 3'd4;
  localparam logic [2:0] Z_TYPE = 3'd5;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  function automatic logic sel_illegal(input logic [2:0] sel);
    return sel[2] & sel[1];
  endfunction
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational decode of inst[31:7] and format select into an XLEN-wide immediate
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     inst,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [31:0] imm32;
  // Every format's sign bit is inst[31], so a 32-bit result sign-extends cleanly to XLEN; zimm has bit 31 clear.
  always_comb begin
    imm32 = (sel == I_TYPE) ? {{20{inst[24]}}, inst[24:13]} :
            (sel == S_TYPE) ? {{20{inst[24]}}, inst[24:18], inst[4:0]} :
            (sel == B_TYPE) ? {{19{inst[24]}}, inst[24], inst[0], inst[23:18], inst[4:1], 1'b0} :
            (sel == U_TYPE) ? {inst[24:5], 12'b0} :
            (sel == J_TYPE) ? {{11{inst[24]}}, inst[24], inst[12:5], inst[13], inst[23:14], 1'b0} :
            (sel == Z_TYPE) ? {27'b0, inst[12:8]} : 32'd0;
    illegal = sel_illegal(sel);
    imm = XLEN'($signed(imm32));
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry skid and saturating illegal-select counter
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [24:0]          in_inst,
  input  logic [2:0]           in_imm_sel,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt
);
  logic [XLEN-1:0]      dec_imm;
  logic                 dec_ill;
  logic [1:0]           state_q, state_d;
  logic [XLEN-1:0]      out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0]     out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic                 out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic                 accept, drain, load_out, load_skid, move_skid;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .inst    (in_inst),
    .sel     (in_imm_sel),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign out_valid   = state_q != ST_EMPTY;
  assign in_ready    = state_q != ST_FULL;
  assign out_imm     = out_imm_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_ill_q;
  assign ill_cnt     = ill_cnt_q;

  // Occupancy transitions: new items go to the output register when it frees up, else into the skid.
  always_comb begin
    accept    = in_valid & in_ready;
    drain     = out_valid & out_ready;
    load_out  = accept & ((state_q == ST_EMPTY) | drain);
    load_skid = accept & (state_q == ST_ONE) & ~drain;
    move_skid = (state_q == ST_FULL) & drain;
    state_d   = (state_q == ST_EMPTY) ? (accept ? ST_ONE : ST_EMPTY) :
                (state_q == ST_ONE)   ? (load_skid ? ST_FULL : (drain & ~accept) ? ST_EMPTY : ST_ONE) :
                (drain ? ST_ONE : ST_FULL);
    out_imm_d  = load_out ? dec_imm : move_skid ? skid_imm_q : out_imm_q;
    out_tag_d  = load_out ? in_tag  : move_skid ? skid_tag_q : out_tag_q;
    out_ill_d  = load_out ? dec_ill : move_skid ? skid_ill_q : out_ill_q;
    skid_imm_d = load_skid ? dec_imm : skid_imm_q;
    skid_tag_d = load_skid ? in_tag  : skid_tag_q;
    skid_ill_d = load_skid ? dec_ill : skid_ill_q;
    ill_cnt_d  = (accept & dec_ill & ~&ill_cnt_q) ? ill_cnt_q + ILL_CNT_W'(1) : ill_cnt_q;
  end

  // State update; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_ill_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
      ill_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_imm_q  <= out_imm_d;
      out_tag_q  <= out_tag_d;
      out_ill_q  <= out_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_ill_q <= skid_ill_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving a 32-bit and a 64-bit/2-bit-counter instance in lockstep
module tb_imm_gen_pipe;
  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [24:0] in_inst;
  logic [2:0]  in_imm_sel;
  logic [31:0] in_tag;
  logic        out_ready;
  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a, out_tag_a;
  logic [7:0]  ill_cnt_a;
  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [31:0] out_tag_b;
  logic [1:0]  ill_cnt_b;
  int          compared = 0;
  int          mismatched = 0;
  exp_t        sb[$];
  exp_t        e;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ILL_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_inst(in_inst),
    .in_imm_sel(in_imm_sel), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_tag(out_tag_a), .out_illegal(out_illegal_a), .ill_cnt(ill_cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_inst(in_inst),
    .in_imm_sel(in_imm_sel), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_tag(out_tag_b), .out_illegal(out_illegal_b), .ill_cnt(ill_cnt_b)
  );

  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] sel);
    case (sel)
      3'd0:    return {{52{ins[31]}}, ins[31:20]};
      3'd1:    return {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2:    return {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3:    return {{32{ins[31]}}, ins[31:12], 12'b0};
      3'd4:    return {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd5:    return {59'b0, ins[19:15]};
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] tg);
    in_valid   = 1'b1;
    in_inst    = ins[31:7];
    in_imm_sel = sel;
    in_tag     = tg;
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cyc();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a && out_ready) begin
        compared++;
        assert (sb.size() > 0) else begin
          mismatched++;
          $error("FAIL sb_extra: observed output tag %h expected no output", out_tag_a);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("imm32", {32'd0, out_imm_a}, {32'd0, e.imm[31:0]});
          chk("imm64", out_imm_b, e.imm);
          chk("tag32", {32'd0, out_tag_a}, {32'd0, e.tag});
          chk("tag64", {32'd0, out_tag_b}, {32'd0, e.tag});
          chk("ill32", {63'd0, out_illegal_a}, {63'd0, e.ill});
          chk("ill64", {63'd0, out_illegal_b}, {63'd0, e.ill});
          chk("valid64", {63'd0, out_valid_b}, 64'd1);
        end
      end
      if (in_valid && in_ready_a)
        sb.push_back('{imm: model_imm({in_inst, 7'b0}, in_imm_sel), tag: in_tag, ill: in_imm_sel[2] & in_imm_sel[1]});
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_imm_sel = '0; in_tag = '0; out_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", {63'd0, out_valid_a}, 64'd0);
    chk("rst_ready", {63'd0, in_ready_a}, 64'd1);
    chk("rst_imm", {32'd0, out_imm_a}, 64'd0);
    chk("rst_tag", {32'd0, out_tag_a}, 64'd0);
    chk("rst_ill", {63'd0, out_illegal_a}, 64'd0);
    chk("rst_cnt", {56'd0, ill_cnt_a}, 64'd0);
    // latency: result registered one edge after accept
    drive(32'h00C48413, 3'd0, 32'd0);
    chk("t1_lat", {63'd0, out_valid_a}, 64'd1);
    chk("t1_imm", {32'd0, out_imm_a}, 64'h0000_000C);
    idle();
    chk("t1_drain", {63'd0, out_valid_a}, 64'd0);
    drive(32'hFFC48413, 3'd0, 32'd1);
    chk("t1_imm_neg", {32'd0, out_imm_a}, 64'hFFFF_FFFC);
    chk("t1_imm_neg64", out_imm_b, 64'hFFFF_FFFF_FFFF_FFFC);
    idle();
    // back-to-back, one per cycle
    drive(32'hFE000EE3, 3'd2, 32'd0);
    chk("t2_b", {32'd0, out_imm_a}, 64'hFFFF_FFFC);
    drive(32'h123452B7, 3'd3, 32'd1);
    chk("t2_u", {32'd0, out_imm_a}, 64'h1234_5000);
    chk("t2_rdy", {63'd0, in_ready_a}, 64'd1);
    drive(32'h340FD073, 3'd5, 32'd2);
    chk("t2_z", {32'd0, out_imm_a}, 64'd31);
    drive(32'h00C48413, 3'd0, 32'd3);
    chk("t2_tag3", {32'd0, out_tag_a}, 64'd3);
    idle();
    // 64-bit sign extension
    drive(32'h80000537, 3'd3, 32'd4);
    chk("t3_u64", out_imm_b, 64'hFFFF_FFFF_8000_0000);
    drive(32'hFFC48413, 3'd0, 32'd5);
    chk("t3_i64", out_imm_b, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(32'h0000F0EF, 3'd4, 32'd6);
    drive(32'hFE112E23, 3'd1, 32'd7);
    idle();
    // back-pressure fills the skid, then drains in order
    out_ready = 1'b0;
    drive(32'h00C48413, 3'd0, 32'd10);
    chk("t4_rdy1", {63'd0, in_ready_a}, 64'd1);
    drive(32'h123452B7, 3'd3, 32'd11);
    chk("t4_full", {63'd0, in_ready_a}, 64'd0);
    chk("t4_full64", {63'd0, in_ready_b}, 64'd0);
    drive(32'hFFC48413, 3'd0, 32'd12);
    chk("t4_hold_rdy", {63'd0, in_ready_a}, 64'd0);
    chk("t4_hold_tag", {32'd0, out_tag_a}, 64'd10);
    chk("t4_hold_imm", {32'd0, out_imm_a}, 64'h0000_000C);
    out_ready = 1'b1;
    cyc();
    chk("t4_skid_out", {32'd0, out_tag_a}, 64'd11);
    chk("t4_rdy_back", {63'd0, in_ready_a}, 64'd1);
    cyc();
    chk("t4_third", {32'd0, out_tag_a}, 64'd12);
    idle();
    chk("t4_empty", {63'd0, out_valid_a}, 64'd0);
    // illegal selects and counter saturation
    drive(32'h12345678, 3'd7, 32'd20);
    chk("t5_ill", {63'd0, out_illegal_a}, 64'd1);
    chk("t5_imm0", {32'd0, out_imm_a}, 64'd0);
    drive(32'hFFFFFFFF, 3'd7, 32'd21);
    drive(32'h80000000, 3'd7, 32'd22);
    chk("t5_sat_early", {62'd0, ill_cnt_b}, 64'd3);
    drive(32'hFFFFFF80, 3'd6, 32'd23);
    idle();
    chk("t5_cnt", {56'd0, ill_cnt_a}, 64'd4);
    chk("t5_sat", {62'd0, ill_cnt_b}, 64'd3);
    // reset while FULL with a request pending
    out_ready = 1'b0;
    drive(32'h00C48413, 3'd0, 32'd40);
    drive(32'h123452B7, 3'd3, 32'd41);
    chk("t6_full", {63'd0, in_ready_a}, 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("t6_valid", {63'd0, out_valid_a}, 64'd0);
    chk("t6_ready", {63'd0, in_ready_a}, 64'd1);
    chk("t6_cnt", {56'd0, ill_cnt_a}, 64'd0);
    chk("t6_cnt64", {62'd0, ill_cnt_b}, 64'd0);
    chk("t6_imm", out_imm_b, 64'd0);
    chk("t6_tag", {32'd0, out_tag_a}, 64'd0);
    drive(32'hFFC48413, 3'd0, 32'd50);
    chk("t6_post", {32'd0, out_imm_a}, 64'hFFFF_FFFC);
    chk("t6_post_valid", {63'd0, out_valid_a}, 64'd1);
    idle();
    idle();
    chk("sb_left", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
